// File: rtl/game_pkg.sv
// Shared types and constants for the falling-brick game sequencer.
package game_pkg;

    localparam int HEIGHT_W = 3;
    localparam int STEP_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_CLEAR = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] COL_LEFT   = 2'd0;
    localparam logic [1:0] COL_CENTRE = 2'd1;
    localparam logic [1:0] COL_RIGHT  = 2'd2;

    function automatic logic [HEIGHT_W-1:0] sat_inc(input logic [HEIGHT_W-1:0] h,
                                                   input logic [HEIGHT_W-1:0] lim);
        return (h >= lim) ? h : h + HEIGHT_W'(1);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Frame divider: emits a one-cycle step strobe on every step_frames-th frame tick.
module step_timer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic [STEP_W-1:0] step_frames,
    input  logic              clear,
    output logic              step
);

    logic [STEP_W-1:0] count;

    // >= rather than == keeps the wrap safe if step_frames ever shrinks mid-count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (frame_tick) begin
                if (count >= step_frames - STEP_W'(1)) begin
                    count <= '0;
                    step  <= 1'b1;
                end else begin
                    count <= count + STEP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: brick spawn, column moves, stacking, row clears and speed-up.
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 30,
    parameter int MIN_FRAMES      = 6,
    parameter int MAX_HEIGHT      = 5
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                land_left,
    input  logic                land_centre,
    input  logic                land_right,
    input  logic                perdu,
    output logic                pulse,
    output logic [1:0]          col,
    output logic [HEIGHT_W-1:0] height_left,
    output logic [HEIGHT_W-1:0] height_centre,
    output logic [HEIGHT_W-1:0] height_right,
    output logic [7:0]          score,
    output logic                game_over,
    output logic [2:0]          state
);

    localparam logic [HEIGHT_W-1:0] HMAX      = HEIGHT_W'(MAX_HEIGHT);
    localparam logic [STEP_W-1:0]   STEP_INIT = STEP_W'(FRAMES_PER_STEP);
    localparam logic [STEP_W-1:0]   STEP_MIN  = STEP_W'(MIN_FRAMES);

    state_t            cur;
    logic [STEP_W-1:0] step_frames;
    logic [1:0]        clear_cnt;
    logic              any_land, multi_land, at_max, all_filled, fall_hold;
    logic [1:0]        land_col;

    // With several landings at once the current column decides which stack grows.
    always_comb begin
        any_land   = land_left | land_centre | land_right;
        multi_land = (land_left & land_centre) | (land_left & land_right) |
                     (land_centre & land_right);
        land_col   = col;
        if (!multi_land) begin
            if (land_left)        land_col = COL_LEFT;
            else if (land_centre) land_col = COL_CENTRE;
            else if (land_right)  land_col = COL_RIGHT;
        end
        at_max     = (height_left == HMAX) || (height_centre == HMAX) || (height_right == HMAX);
        all_filled = (height_left != '0) && (height_centre != '0) && (height_right != '0);
        fall_hold  = (cur == S_FALL) && !perdu && !at_max && !any_land;
    end

    step_timer u_step_timer (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick & fall_hold),
        .step_frames (step_frames),
        .clear       (cur == S_SPAWN),
        .step        (pulse)
    );

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur           <= S_IDLE;
            col           <= COL_CENTRE;
            height_left   <= '0;
            height_centre <= '0;
            height_right  <= '0;
            score         <= '0;
            game_over     <= 1'b0;
            step_frames   <= STEP_INIT;
            clear_cnt     <= '0;
        end else begin
            case (cur)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        cur           <= S_SPAWN;
                        height_left   <= '0;
                        height_centre <= '0;
                        height_right  <= '0;
                        score         <= '0;
                        game_over     <= 1'b0;
                        step_frames   <= STEP_INIT;
                        clear_cnt     <= '0;
                    end
                end
                S_SPAWN: begin
                    col <= COL_CENTRE;
                    cur <= S_FALL;
                end
                S_FALL: begin
                    if (perdu || at_max) begin
                        cur       <= S_OVER;
                        game_over <= 1'b1;
                    end else if (any_land) begin
                        case (land_col)
                            COL_LEFT:   height_left   <= sat_inc(height_left, HMAX);
                            COL_CENTRE: height_centre <= sat_inc(height_centre, HMAX);
                            COL_RIGHT:  height_right  <= sat_inc(height_right, HMAX);
                            default:    ;
                        endcase
                        cur <= S_CLEAR;
                    end else if (btn_left && !btn_right && col != COL_LEFT) begin
                        col <= col - 2'd1;
                    end else if (btn_right && !btn_left && col != COL_RIGHT) begin
                        col <= col + 2'd1;
                    end
                end
                S_CLEAR: begin
                    cur <= S_SPAWN;
                    if (all_filled) begin
                        height_left   <= height_left - HEIGHT_W'(1);
                        height_centre <= height_centre - HEIGHT_W'(1);
                        height_right  <= height_right - HEIGHT_W'(1);
                        score         <= (score == 8'hFF) ? score : score + 8'd1;
                        clear_cnt     <= clear_cnt + 2'd1;
                        if (clear_cnt == 2'd3)
                            step_frames <= (step_frames < STEP_MIN + STEP_W'(4)) ?
                                           STEP_MIN : step_frames - STEP_W'(4);
                    end
                end
                default: cur <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector table plus multi-cycle sequences.
module tb_game_sequencer;

    localparam logic [7:0] I_NONE  = 8'h00;
    localparam logic [7:0] I_START = 8'h80;
    localparam logic [7:0] I_TICK  = 8'h40;
    localparam logic [7:0] I_BL    = 8'h20;
    localparam logic [7:0] I_BR    = 8'h10;
    localparam logic [7:0] I_LL    = 8'h08;
    localparam logic [7:0] I_LC    = 8'h04;
    localparam logic [7:0] I_LR    = 8'h02;
    localparam logic [7:0] I_PD    = 8'h01;

    typedef struct {
        logic [7:0] in;
        logic [2:0] st;
        logic [1:0] col;
        logic [2:0] hl, hc, hr;
        logic [7:0] sc;
        logic       go;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       land_left = 1'b0, land_centre = 1'b0, land_right = 1'b0, perdu = 1'b0;
    logic       pulse, game_over;
    logic [1:0] col;
    logic [2:0] height_left, height_centre, height_right, state;
    logic [7:0] score;

    int passed = 0;
    int total  = 0;

    vec_t vecs[27];

    game_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .land_left     (land_left),
        .land_centre   (land_centre),
        .land_right    (land_right),
        .perdu         (perdu),
        .pulse         (pulse),
        .col           (col),
        .height_left   (height_left),
        .height_centre (height_centre),
        .height_right  (height_right),
        .score         (score),
        .game_over     (game_over),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic [7:0] v);
        {start, frame_tick, btn_left, btn_right, land_left, land_centre, land_right, perdu} = v;
        @(posedge clk);
        #1;
        {start, frame_tick, btn_left, btn_right, land_left, land_centre, land_right, perdu} = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] packOutputs();
        return {8'h00, state, col, height_left, height_centre, height_right, score, game_over, pulse};
    endfunction

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(I_NONE);
        applyStimulus(I_NONE);
        reset = 1'b0;
    endtask

    task automatic enterFall();
        applyStimulus(I_START);
        applyStimulus(I_NONE);
    endtask

    task automatic doClear();
        applyStimulus(I_LL); applyStimulus(I_NONE); applyStimulus(I_NONE);
        applyStimulus(I_LC); applyStimulus(I_NONE); applyStimulus(I_NONE);
        applyStimulus(I_LR); applyStimulus(I_NONE); applyStimulus(I_NONE);
    endtask

    // Counts frame ticks until the step strobe appears; -1 if it never does.
    task automatic measurePeriod(output int n);
        bit found = 0;
        n = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus(I_TICK);
            n++;
            if (pulse) found = 1;
        end
        if (!found) n = -1;
    endtask

    initial begin
        int pulses, pulse_at, period;

        vecs[0]  = '{I_NONE,      3'd0, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[1]  = '{I_START,     3'd1, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[2]  = '{I_START,     3'd2, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[3]  = '{I_BL,        3'd2, 2'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[4]  = '{I_BL,        3'd2, 2'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[5]  = '{I_BL | I_BR, 3'd2, 2'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[6]  = '{I_BR,        3'd2, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[7]  = '{I_BR,        3'd2, 2'd2, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[8]  = '{I_BR,        3'd2, 2'd2, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[9]  = '{I_START,     3'd2, 2'd2, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[10] = '{I_LL,        3'd3, 2'd2, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[11] = '{I_NONE,      3'd1, 2'd2, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[12] = '{I_NONE,      3'd2, 2'd1, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[13] = '{I_LC,        3'd3, 2'd1, 3'd1, 3'd1, 3'd0, 8'd0, 1'b0};
        vecs[14] = '{I_NONE,      3'd1, 2'd1, 3'd1, 3'd1, 3'd0, 8'd0, 1'b0};
        vecs[15] = '{I_NONE,      3'd2, 2'd1, 3'd1, 3'd1, 3'd0, 8'd0, 1'b0};
        vecs[16] = '{I_LR,        3'd3, 2'd1, 3'd1, 3'd1, 3'd1, 8'd0, 1'b0};
        vecs[17] = '{I_NONE,      3'd1, 2'd1, 3'd0, 3'd0, 3'd0, 8'd1, 1'b0};
        vecs[18] = '{I_NONE,      3'd2, 2'd1, 3'd0, 3'd0, 3'd0, 8'd1, 1'b0};
        vecs[19] = '{I_LL | I_LR, 3'd3, 2'd1, 3'd0, 3'd1, 3'd0, 8'd1, 1'b0};
        vecs[20] = '{I_NONE,      3'd1, 2'd1, 3'd0, 3'd1, 3'd0, 8'd1, 1'b0};
        vecs[21] = '{I_NONE,      3'd2, 2'd1, 3'd0, 3'd1, 3'd0, 8'd1, 1'b0};
        vecs[22] = '{I_LC | I_PD, 3'd4, 2'd1, 3'd0, 3'd1, 3'd0, 8'd1, 1'b1};
        vecs[23] = '{I_START,     3'd1, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[24] = '{I_NONE,      3'd2, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0};
        vecs[25] = '{I_PD,        3'd4, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b1};
        vecs[26] = '{I_NONE,      3'd4, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b1};

        doReset();
        checkOutput("reset_state", packOutputs(),
                    {8'h00, 3'd0, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0});

        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), packOutputs(),
                        {8'h00, vecs[i].st, vecs[i].col, vecs[i].hl, vecs[i].hc, vecs[i].hr,
                         vecs[i].sc, vecs[i].go, 1'b0});
        end

        // Gravity strobe lands exactly one cycle after the 30th tick.
        doReset();
        enterFall();
        pulses = 0;
        pulse_at = -1;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus(I_TICK);
            if (pulse) begin
                pulses++;
                pulse_at = i;
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(I_NONE);
            if (pulse) pulses++;
        end
        checkOutput("pulse_count", pulses, 1);
        checkOutput("pulse_at_tick", pulse_at, 30);
        checkOutput("pulse_col", {30'd0, col}, 1);

        // Speed-up every fourth clear, floored at MIN_FRAMES.
        doReset();
        enterFall();
        measurePeriod(period);
        checkOutput("period_initial", period, 30);
        for (int i = 0; i < 4; i++) doClear();
        measurePeriod(period);
        checkOutput("period_after4", period, 26);
        for (int i = 0; i < 20; i++) doClear();
        measurePeriod(period);
        checkOutput("period_after24", period, 6);
        for (int i = 0; i < 8; i++) doClear();
        measurePeriod(period);
        checkOutput("period_after32", period, 6);
        checkOutput("score_after32", score, 32);

        // A stack reaching MAX_HEIGHT ends the game on the next FALL cycle.
        doReset();
        enterFall();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(I_LL);
            checkOutput($sformatf("stack_left%0d", i), height_left, i);
            applyStimulus(I_NONE);
            applyStimulus(I_NONE);
        end
        applyStimulus(I_NONE);
        checkOutput("max_height_over", {state, game_over, height_left}, {3'd4, 1'b1, 3'd5});

        // Reset wins over a frame tick that would otherwise fire the strobe.
        doReset();
        enterFall();
        applyStimulus(I_LL);
        applyStimulus(I_NONE);
        applyStimulus(I_NONE);
        applyStimulus(I_BR);
        for (int i = 0; i < 29; i++) applyStimulus(I_TICK);
        reset = 1'b1;
        applyStimulus(I_TICK);
        reset = 1'b0;
        checkOutput("reset_midfall", packOutputs(),
                    {8'h00, 3'd0, 2'd1, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0});
        applyStimulus(I_NONE);
        checkOutput("reset_midfall_nopulse", {state, pulse}, {3'd0, 1'b0});

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
